// File: rtl/regfile.sv
// regfile: general-purpose register file with a per-register reservation
// scoreboard. Two combinational read ports, one writeback port, and a
// reservation request from decode that targets the port-0 register.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a writeback
// is forwarded to the read ports and clears the stall in the same cycle.
// When it is undefined, reads return only stored data.
module regfile #(
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_REG  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_REG-1:0]  r0_num_i,
  input  logic [W_REG-1:0]  r1_num_i,
  output logic [W_DATA-1:0] r0_data_o,
  output logic [W_DATA-1:0] r1_data_o,
  input  logic              w_reserve_i,
  output logic              reserved_o,
  input  logic              wb_v_i,
  input  logic [W_REG-1:0]  wb_num_i,
  input  logic [W_DATA-1:0] wb_data_i,
  output logic              idle_o
);

  localparam int unsigned N_REG = 1 << W_REG;

  logic [W_DATA-1:0] data_q [N_REG];
  logic [W_DATA-1:0] data_d [N_REG];
  logic [N_REG-1:0]  res_q;
  logic [N_REG-1:0]  res_d;
  logic [N_REG-1:0]  res_eff;
  logic              idle_q;
  logic              accept;

  // Read ports and stall view of the scoreboard, with optional writeback bypass
  always_comb begin
    res_eff   = res_q;
    r0_data_o = data_q[r0_num_i];
    r1_data_o = data_q[r1_num_i];
`ifdef REGFILE_BYPASS_EN
    if (wb_v_i) begin
      res_eff[wb_num_i] = 1'b0;
      if (wb_num_i == r0_num_i) r0_data_o = wb_data_i;
      if (wb_num_i == r1_num_i) r1_data_o = wb_data_i;
    end
`endif
    reserved_o = res_eff[r0_num_i] | res_eff[r1_num_i];
    accept     = w_reserve_i & ~reserved_o;
  end

  // Next-state data and scoreboard; a new reservation wins over a same-register writeback
  always_comb begin
    data_d = data_q;
    res_d  = res_q;
    if (wb_v_i) begin
      data_d[wb_num_i] = wb_data_i;
      res_d[wb_num_i]  = 1'b0;
    end
    if (accept) begin
      res_d[r0_num_i] = 1'b1;
    end
  end

  // State registers with synchronous reset overriding any concurrent update
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      res_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      data_q <= data_d;
      res_q  <= res_d;
      idle_q <= ~|res_d;
    end
  end

  assign idle_o = idle_q;

endmodule
